// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit (master) and instruction memory (slave).
// A transfer completes on the rising edge where imem_req and imem_ack are both high.
interface if_fetch_unit_if #(
  parameter int unsigned WORD_WIDTH = 32
);

  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [WORD_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs the imem req/ack handshake and buffers
// returned words in a prefetch FIFO that feeds decode; taken branches flush and redirect.
module if_fetch_unit #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_address,
  if_fetch_unit_if.master       mem,
  output logic                  valid_out,
  output logic [WORD_WIDTH-1:0] PC_out,
  output logic [WORD_WIDTH-1:0] instruction_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WORD_WIDTH-1:0] PC_STEP  = WORD_WIDTH'(4);
  localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(3);

  // ST_DROP: a request issued before a branch is still outstanding; its data must be discarded.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] word;
  } entry_t;

  state_t                state, state_n;
  logic [WORD_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [WORD_WIDTH-1:0] target_pc, target_pc_n;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]      count, count_n;
  logic                  req_q, req_n;
  logic                  valid_n;
  entry_t                head_q, head_n;
  entry_t                push_entry;
  entry_t                fifo_mem [FIFO_DEPTH];
  logic                  ack_acc;
  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] branch_tgt;

  assign mem.imem_req  = req_q;
  assign mem.imem_addr = fetch_pc;

  assign PC_out          = head_q.pc;
  assign instruction_out = head_q.word;

  // Next-state: branch flush/redirect, drop handling, FIFO push/pop and next head entry.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    target_pc_n = target_pc;
    rd_ptr_n    = rd_ptr;
    wr_ptr_n    = wr_ptr;
    count_n     = count;
    push        = 1'b0;
    pop         = 1'b0;
    ack_acc     = req_q & mem.imem_ack;
    branch_tgt  = branch_address & ALIGN_MASK;
    push_entry  = '{pc: fetch_pc + PC_STEP, word: mem.imem_rdata};

    if (branch_taken) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
      if (ack_acc || !req_q) begin
        fetch_pc_n = branch_tgt;
        state_n    = ST_FETCH;
      end else begin
        // Keep the pending address stable; redirect once its ack arrives.
        target_pc_n = branch_tgt;
        state_n     = ST_DROP;
      end
    end else begin
      pop = valid_out & ~Freeze;
      unique case (state)
        ST_DROP: begin
          if (ack_acc) begin
            fetch_pc_n = target_pc;
            state_n    = ST_FETCH;
          end
        end
        default: begin
          if (ack_acc) begin
            push       = 1'b1;
            fetch_pc_n = fetch_pc + PC_STEP;
          end
        end
      endcase
      if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_n = count + CNT_W'(1);
        2'b01:   count_n = count - CNT_W'(1);
        default: count_n = count;
      endcase
    end

    req_n   = (state_n == ST_DROP) | (count_n < CNT_FULL);
    valid_n = (count_n != '0);

    // A word pushed into an otherwise-empty FIFO becomes the head without a storage round trip.
    if (!valid_n) begin
      head_n = '0;
    end else if (push && (wr_ptr == rd_ptr_n)) begin
      head_n = push_entry;
    end else begin
      head_n = fifo_mem[rd_ptr_n];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      fetch_pc  <= '0;
      target_pc <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      req_q     <= 1'b1;
      valid_out <= 1'b0;
      head_q    <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      target_pc <= target_pc_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      count     <= count_n;
      req_q     <= req_n;
      valid_out <= valid_n;
      head_q    <= head_n;
    end
  end

  // Prefetch storage; entries are only read after being written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and random-delay bench for if_fetch_unit with a small imem model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic        valid_out;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;

  logic        force_hold = 1'b0;
  int          max_delay = 0;
  int          wait_cnt;

  int checks = 0;
  int errors = 0;

  if_fetch_unit_if #(.WORD_WIDTH(32)) bus ();

  if_fetch_unit #(.WORD_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .Freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_address  (branch_address),
    .mem             (bus),
    .valid_out       (valid_out),
    .PC_out          (PC_out),
    .instruction_out (instruction_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: acks after wait_cnt cycles of a pending request unless held off.
  assign bus.imem_ack   = bus.imem_req & ~force_hold & (wait_cnt == 0);
  assign bus.imem_rdata = word_of(bus.imem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
    end else if (bus.imem_req && bus.imem_ack) begin
      wait_cnt <= int'($urandom_range(32'(max_delay), 0));
    end else if (bus.imem_req && wait_cnt > 0) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Branch while a request to 0x10 is held off; optionally a second branch during the wait.
  task automatic run_drop(input logic two);
    logic [31:0] tgt;
    tgt = two ? 32'h300 : 32'h200;
    branch_taken = 1'b1; branch_address = 32'h10;
    @(negedge clk);
    branch_taken = 1'b0; force_hold = 1'b1;
    chk("drop_addr0", bus.imem_addr, 32'h10);
    chk("drop_valid0", valid_out, 1'b0);
    @(negedge clk);
    chk("drop_addr1", bus.imem_addr, 32'h10);
    chk("drop_req1", bus.imem_req, 1'b1);
    branch_taken = 1'b1; branch_address = 32'h200;
    @(negedge clk);
    chk("drop_addr2", bus.imem_addr, 32'h10);
    chk("drop_valid2", valid_out, 1'b0);
    branch_taken = two; branch_address = 32'h300;
    @(negedge clk);
    chk("drop_addr3", bus.imem_addr, 32'h10);
    branch_taken = 1'b0; force_hold = 1'b0;
    @(negedge clk);
    chk("drop_valid4", valid_out, 1'b0);
    chk("drop_addr4", bus.imem_addr, tgt);
    @(negedge clk);
    chk("drop_valid5", valid_out, 1'b1);
    chk("drop_pc5", PC_out, tgt + 32'd4);
    chk("drop_instr5", instruction_out, word_of(tgt));
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_pending;
    logic        saw_wrap;
    logic        fz;
    int          n_out;

    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_req", bus.imem_req, 1'b1);
    chk("rel_addr", bus.imem_addr, 32'h0);

    // Zero-wait streaming
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("str_valid", valid_out, 1'b1);
      chk("str_pc", PC_out, 32'(4 * k));
      chk("str_instr", instruction_out, word_of(32'(4 * k - 4)));
      chk("str_addr", bus.imem_addr, 32'(4 * k));
    end

    // Freeze: FIFO fills, request stops, head is held
    freeze = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("frz_pc", PC_out, 32'd20);
      chk("frz_instr", instruction_out, word_of(32'd16));
      chk("frz_req", bus.imem_req, (i >= 3) ? 1'b0 : 1'b1);
    end
    freeze = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("drn_valid", valid_out, 1'b1);
      chk("drn_pc", PC_out, 32'(24 + 4 * j));
      chk("drn_instr", instruction_out, word_of(32'(20 + 4 * j)));
    end

    // Branch with memory acking every cycle
    branch_taken = 1'b1; branch_address = 32'h100;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("br_valid", valid_out, 1'b0);
    chk("br_addr", bus.imem_addr, 32'h100);
    @(negedge clk);
    chk("br_valid1", valid_out, 1'b1);
    chk("br_pc1", PC_out, 32'h104);
    chk("br_instr1", instruction_out, word_of(32'h100));
    @(negedge clk);
    chk("br_pc2", PC_out, 32'h108);

    run_drop(1'b0);
    run_drop(1'b1);

    // Branch coinciding with an ack; low address bits are ignored
    branch_taken = 1'b1; branch_address = 32'h402;
    @(negedge clk);
    branch_taken = 1'b0;
    chk("sim_valid", valid_out, 1'b0);
    chk("sim_addr", bus.imem_addr, 32'h400);
    @(negedge clk);
    chk("sim_pc", PC_out, 32'h404);
    chk("sim_instr", instruction_out, word_of(32'h400));

    // Random ack delays and freeze across the address wrap
    branch_taken = 1'b1; branch_address = 32'hFFFF_FFF0;
    @(negedge clk);
    branch_taken = 1'b0;
    max_delay = 5;
    exp_pc = 32'hFFFF_FFF4;
    prev_pending = 1'b0;
    prev_addr = '0;
    saw_wrap = 1'b0;
    n_out = 0;
    for (int c = 0; c < 300; c++) begin
      if (prev_pending) chk("hs_stable", bus.imem_addr, prev_addr);
      if (valid_out) begin
        chk("rnd_pc", PC_out, exp_pc);
        chk("rnd_instr", instruction_out, word_of(exp_pc - 32'd4));
        if (exp_pc == 32'h0 && PC_out == 32'h0) saw_wrap = 1'b1;
      end
      fz = ($urandom_range(3, 0) == 0);
      freeze = fz;
      if (valid_out && !fz) begin
        exp_pc = exp_pc + 32'd4;
        n_out++;
      end
      prev_pending = bus.imem_req & ~bus.imem_ack;
      prev_addr = bus.imem_addr;
      @(negedge clk);
    end
    chk("wrap_seen", saw_wrap, 1'b1);
    chk("rnd_progress", (n_out >= 20), 1'b1);

    // Reset in the middle of a held-off request
    freeze = 1'b0;
    max_delay = 0;
    repeat (8) @(negedge clk);
    force_hold = 1'b1;
    freeze = 1'b1;
    @(negedge clk);
    chk("pre_rst_valid", valid_out, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid_out, 1'b0);
    chk("mid_rst_pc", PC_out, 32'h0);
    chk("mid_rst_instr", instruction_out, 32'h0);
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; force_hold = 1'b0; freeze = 1'b0;
    #1;
    chk("post_rst_req", bus.imem_req, 1'b1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk("post_rst_pc", PC_out, 32'h4);
    chk("post_rst_instr", instruction_out, word_of(32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage that sits directly upstream of the decode stage and produces its `PC_in` / `instruction_in` pair. It owns the fetch program counter and runs a req/ack handshake to instruction memory. It buffers returned words in a small prefetch FIFO, so memory wait states and decode freezes are decoupled. Taken branches from the execute stage flush the buffer and redirect fetch, including while a memory request is still in flight.

## Interface
Parameters:
- `WORD_WIDTH`, 32, instruction and address width
- `FIFO_DEPTH`, 4, prefetch entries; power of two, ≥2

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Freeze`  in  1  hazard stall from hazard unit; holds the current output entry
- `branch_taken`  in  1  one-cycle redirect pulse from EX
- `branch_address`  in  WORD_WIDTH  redirect target
- `imem_req`  out  1  memory request
- `imem_addr`  out  WORD_WIDTH  request address, word aligned
- `imem_ack`  in  1  memory accepts the request and returns data this cycle
- `imem_rdata`  in  WORD_WIDTH  instruction word, valid when `imem_ack`=1
- `valid_out`  out  1  FIFO head holds a real instruction
- `PC_out`  out  WORD_WIDTH  fetch address + 4 of the head instruction
- `instruction_out`  out  WORD_WIDTH  head instruction word

## Operation
- State:
  - `fetch_pc`
  - `target_pc`
  - `drop` flag
  - FIFO storage of {pc+4, word}
  - read/write pointers
  - `count` (0..FIFO_DEPTH)
- Outputs:
  - `imem_addr` = `fetch_pc`.
  - `imem_req` = `drop` | (`count` < FIFO_DEPTH). It is a function of registered state only and never depends on `imem_ack`.
- Handshake:
  - Once `imem_req` rises, it stays high and `imem_addr` stays stable until the cycle `imem_ack`=1.
  - A transaction completes on the edge where `imem_req`&`imem_ack`. Memory may ack in the same cycle as the request.
- Accepted ack, `drop`=0, no branch:
  - Push {`fetch_pc`+4, `imem_rdata`}.
  - `fetch_pc` += 4.
- Pop: occurs when `valid_out`&~`Freeze`; the read pointer advances.
  - Push and pop on the same edge leave `count` unchanged.
  - Full FIFO cannot receive an ack, because `imem_req` is low.
- Head outputs:
  - `valid_out` = (`count`≠0).
  - When `count`=0, `PC_out`=0 and `instruction_out`=0.
  - The ID/EX register must treat `valid_out`=0 as a bubble.
- Branch (`branch_taken`=1), highest priority, overrides `Freeze` and push:
  - FIFO is flushed: `count`←0, pointers←0.
  - If ack arrives this cycle, or no request is pending: the returned word is discarded and `fetch_pc`←`branch_address`.
  - If `imem_req`&~`imem_ack`: `drop`←1 and `target_pc`←`branch_address`. `fetch_pc` is held, so the pending request stays stable.
- `drop`=1:
  - The next ack is discarded, `fetch_pc`←`target_pc`, `drop`←0.
  - A further branch while `drop`=1 only overwrites `target_pc` and flushes again.
- Arithmetic:
  - PC increments are modulo 2^WORD_WIDTH; 0xFFFFFFFC+4 wraps to 0.
  - Low two bits of `branch_address` are forced to 0.

## Timing
- Reset values, asynchronous:
  - `fetch_pc`=0, `target_pc`=0, `drop`=0, `count`=0.
  - `valid_out`=0, `PC_out`=0, `instruction_out`=0.
  - `imem_req` is 1 with `imem_addr`=0 as soon as `rst` is deasserted.
- Reset asserted mid-transaction: all state clears immediately. After release, the block re-requests address 0, and memory must accept the abandoned request being dropped.
- Latency: an ack at edge N makes the word visible at the outputs after edge N (assuming the FIFO was empty).
- Zero-wait memory gives 1 instruction per cycle.
- Branch at edge N with zero-wait memory: the request for `branch_address` is issued in cycle N+1, and its target is at the head after edge N+1.
- `Freeze` never affects `imem_req`. Fetch continues until the FIFO is full.

## Test plan
- Reset release, zero-wait memory (ack=1 always), no freeze:
  - Addresses 0,4,8,… on consecutive cycles.
  - After the first edge: `valid_out`=1, `PC_out`=4, then 8, 12 each cycle.
- Freeze held 6 cycles from steady state:
  - `count` reaches 4 and `imem_req` drops to 0.
  - Head output is unchanged throughout.
  - On release, the 4 entries drain in order with no loss or duplicate.
- Branch to 0x100 with memory acking every cycle:
  - FIFO is flushed and `valid_out`=0 the next cycle.
  - Next `imem_addr`=0x100.
  - First valid `PC_out`=0x104.
- Branch to 0x200 while a request to 0x10 is pending (ack withheld 3 cycles):
  - `imem_addr` stays 0x10 until ack, and that word is discarded.
  - Next request is 0x200 and the first valid `PC_out`=0x204.
  - A second branch to 0x300 during the wait must win instead.
- Simultaneous branch and ack: the acked word is dropped and the next `imem_addr`=branch target.
- Random ack delays 0–5 cycles with random freeze, checked against a reference PC model:
  - Output stream is sequential.
  - Handshake stability holds (`imem_addr` constant while req&~ack).
  - Address wrap from 0xFFFFFFFC to 0 is observed.
  - `rst` pulsed mid-wait returns all outputs to 0 within the same cycle.
